// File: rtl/nic_sim_pkg.sv
// Shared types for the NIC receive-path simulation blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package nic_sim_pkg;

  // Default stream geometry used by the receive path and its bench.
  localparam int ENTRY_DATAW = 64;
  localparam int ENTRY_KEEPW = ENTRY_DATAW / 8;
  localparam int ENTRY_W     = ENTRY_DATAW + ENTRY_KEEPW + 1;

  // Ingress frame state: keep storing beats, or swallow the rest of a frame
  // that has already been found not to fit.
  typedef enum logic {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } rx_state_t;

  // One storage entry, tlast in the MSB so a beat packs as {last, keep, data}.
  typedef struct packed {
    logic                   last;
    logic [ENTRY_KEEPW-1:0] keep;
    logic [ENTRY_DATAW-1:0] data;
  } rx_entry_t;

endpackage

// File: rtl/nic_sim_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Latency: read data valid one clock after rd_en; write visible to reads next cycle.
// Backpressure: none; read register holds its value while rd_en is low.
module nic_sim_sdp_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_dat,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_dat
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage array: contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_dat;
    end
  end

  // Read register doubles as the egress output register, so it resets to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dat <= '0;
    end else if (rd_en) begin
      rd_dat <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/nic_rx_frame_fifo.sv
// Store-and-forward receive frame buffer: only complete frames reach egress.
// Latency: frame committed on its tlast edge; first beat on egress one edge later.
// Backpressure: ingress never stalls (oversize/overflow frames dropped whole); egress honours tready.
module nic_rx_frame_fifo
  import nic_sim_pkg::*;
#(
  parameter int DATAW = 64,
  parameter int KEEPW = DATAW / 8,
  parameter int DEPTH = 512,
  parameter int CNTW  = 32
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic [DATAW-1:0]         s_axis_tdata,
  input  logic [KEEPW-1:0]         s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [DATAW-1:0]         m_axis_tdata,
  output logic [KEEPW-1:0]         m_axis_tkeep,
  output logic                     m_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     drop_pulse,
  output logic [CNTW-1:0]          frame_cnt,
  output logic [CNTW-1:0]          drop_cnt,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATAW + KEEPW + 1;

  rx_state_t     state;
  rx_state_t     state_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] used;
  logic          full;
  logic          wr_en;
  logic          commit;
  logic          drop;
  logic          out_vld;
  logic          load;
  logic [EW-1:0] rd_dat;

  // The sink models a MAC: it is ready whenever it is out of reset.
  assign s_axis_tready = S_AXI_ARESETN;

  // Occupancy uses the registered read pointer, so a pop in the same cycle
  // never makes room for a beat; this errs by one entry on the safe side.
  assign used  = wr_ptr - rd_ptr;
  assign full  = (used == PW'(DEPTH));
  assign level = used;

  // Ingress next-state: store, rewind to the last commit, or swallow a frame.
  always_comb begin
    state_nxt  = state;
    wr_ptr_nxt = wr_ptr;
    wr_en      = 1'b0;
    commit     = 1'b0;
    drop       = 1'b0;
    case (state)
      ACCEPT: begin
        if (s_axis_tvalid) begin
          if (!full) begin
            wr_en      = 1'b1;
            wr_ptr_nxt = wr_ptr + PW'(1);
            commit     = s_axis_tlast;
          end else begin
            wr_ptr_nxt = wr_commit;
            if (s_axis_tlast) begin
              drop = 1'b1;
            end else begin
              state_nxt = DISCARD;
            end
          end
        end
      end
      DISCARD: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          state_nxt = ACCEPT;
          drop      = 1'b1;
        end
      end
    endcase
  end

  // Ingress state, write pointers, statistics and the drop pulse.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state      <= ACCEPT;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      frame_cnt  <= '0;
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= wr_ptr_nxt;
      drop_pulse <= drop;
      if (commit) begin
        wr_commit <= wr_ptr_nxt;
        frame_cnt <= frame_cnt + CNTW'(1);
      end
      if (drop) begin
        drop_cnt <= drop_cnt + CNTW'(1);
      end
    end
  end

  // Egress only ever reads up to wr_commit, so a rewind cannot touch it.
  assign load = (rd_ptr != wr_commit) && (!out_vld || m_axis_tready);

  // Egress read pointer and output-valid flag.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_ptr  <= '0;
      out_vld <= 1'b0;
    end else if (load) begin
      rd_ptr  <= rd_ptr + PW'(1);
      out_vld <= 1'b1;
    end else if (m_axis_tready) begin
      out_vld <= 1'b0;
    end
  end

  nic_sim_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (S_AXI_ACLK),
    .rst_n   (S_AXI_ARESETN),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_dat  ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .rd_en   (load),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_dat  (rd_dat)
  );

  assign m_axis_tvalid = out_vld;
  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = rd_dat;

endmodule
